// File: rtl/ser_pkg.sv
// Shared types and helpers for the piso_serializer block.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Bit-position counter for one serial frame; tc flags the final data bit (WIDTH-1).
module bit_counter
  import ser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      clear,
  input  logic                      inc,
  output logic [cnt_w(WIDTH)-1:0]   cnt,
  output logic                      tc
);

  localparam int              CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  // A new frame always starts at bit 0, so load and clear share the same target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load || clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with frame_start/last_bit markers.
// Define PARITY_EN to append one even-parity bit after the data bits.
module piso_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             last_bit
);

  localparam int            CW     = cnt_w(WIDTH);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`ifdef PARITY_EN
  localparam bit DATA_ENDS_FRAME = 1'b0;
`else
  localparam bit DATA_ENDS_FRAME = 1'b1;
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             accept;
  logic             final_cycle;
  logic             load_bit;
  logic             shift_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shift_rest;

`ifdef PARITY_EN
  logic parity;
  assign final_cycle = (state == PARITY);
`else
  assign final_cycle = (state == SHIFT) && tc;
`endif

  assign accept = in_valid && in_ready;

  // shreg holds only the bits not yet shown, so the first bit goes straight to ser_out.
  assign load_bit   = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
  assign load_rest  = MSB_FIRST ? {in_data[WIDTH-2:0], 1'b0} : {1'b0, in_data[WIDTH-1:1]};
  assign shift_bit  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign shift_rest = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .clear(final_cycle && !accept),
    .inc  ((state == SHIFT) && !tc),
    .cnt  (cnt),
    .tc   (tc)
  );

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shreg       <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      last_bit    <= 1'b0;
      in_ready    <= 1'b1;
`ifdef PARITY_EN
      parity      <= 1'b0;
`endif
    end else begin
      frame_start <= 1'b0;
      if (accept) begin
        state       <= SHIFT;
        shreg       <= load_rest;
        ser_out     <= load_bit;
        ser_valid   <= 1'b1;
        frame_start <= 1'b1;
        last_bit    <= 1'b0;
        in_ready    <= 1'b0;
`ifdef PARITY_EN
        parity      <= ^in_data;
`endif
      end else if (final_cycle || state == IDLE) begin
        state     <= IDLE;
        ser_out   <= 1'b0;
        ser_valid <= 1'b0;
        last_bit  <= 1'b0;
        in_ready  <= 1'b1;
      end else if (state == SHIFT && !tc) begin
        // Look one bit ahead so last_bit and in_ready land on the final cycle itself.
        shreg    <= shift_rest;
        ser_out  <= shift_bit;
        last_bit <= DATA_ENDS_FRAME && (cnt == PENULT);
        in_ready <= DATA_ENDS_FRAME && (cnt == PENULT);
      end
`ifdef PARITY_EN
      else begin
        state    <= PARITY;
        ser_out  <= parity;
        last_bit <= 1'b1;
        in_ready <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share stimulus,
// each checked every cycle against a queue of expected frame bits.
module tb_piso_serializer;

  localparam int WIDTH = 8;
`ifdef PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic m_ready, m_ser, m_sv, m_fs, m_lb;
  logic l_ready, l_ser, l_sv, l_fs, l_lb;

  int compared   = 0;
  int mismatched = 0;

  // Expected frame cycles per instance, entry = {bit, frame_start, last_bit}; head is on the wire.
  logic [2:0] qm[$];
  logic [2:0] ql[$];
  // Packed as {ser_out, ser_valid, frame_start, last_bit, in_ready}.
  logic [4:0] exp_m, exp_l;
  logic       last_acc;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_ready), .in_data(in_data),
    .ser_out(m_ser), .ser_valid(m_sv), .frame_start(m_fs), .last_bit(m_lb)
  );

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_ready), .in_data(in_data),
    .ser_out(l_ser), .ser_valid(l_sv), .frame_start(l_fs), .last_bit(l_lb)
  );

  function automatic logic [4:0] obs_m();
    return {m_ser, m_sv, m_fs, m_lb, m_ready};
  endfunction

  function automatic logic [4:0] obs_l();
    return {l_ser, l_sv, l_fs, l_lb, l_ready};
  endfunction

  task automatic push_frame(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) begin
      qm.push_back({w[WIDTH-1-i], i == 0, i == FL - 1});
      ql.push_back({w[i],         i == 0, i == FL - 1});
    end
`ifdef PARITY_EN
    qm.push_back({^w, 1'b0, 1'b1});
    ql.push_back({^w, 1'b0, 1'b1});
`endif
  endtask

  // One clock of the reference: the block is ready when nothing or only the final frame cycle is pending.
  task automatic step();
    @(posedge clk);
    last_acc = in_valid && (qm.size() <= 1);
    if (qm.size() > 0) begin
      qm.delete(0);
      ql.delete(0);
    end
    if (last_acc) push_frame(in_data);
    #1;
    exp_m = (qm.size() == 0) ? 5'b00001 : {qm[0][2], 1'b1, qm[0][1], qm[0][0], qm.size() <= 1};
    exp_l = (ql.size() == 0) ? 5'b00001 : {ql[0][2], 1'b1, ql[0][1], ql[0][0], ql.size() <= 1};
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    compared++;
    if ({obs_m(), obs_l()} !== {5'b00001, 5'b00001}) begin
      mismatched++;
      $display("FAIL reset_async: got m=%b l=%b want 00001", obs_m(), obs_l());
    end
    repeat (2) @(negedge clk);
    compared++;
    if ({obs_m(), obs_l()} !== {5'b00001, 5'b00001}) begin
      mismatched++;
      $display("FAIL reset_held: got m=%b l=%b want 00001", obs_m(), obs_l());
    end
    rst = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [WIDTH-1:0] wm, wl;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    for (int c = 1; c <= FL + 1; c++) begin
      step();
      if (c == 1) in_valid = 1'b0;
      if (c <= WIDTH) begin
        wm = {wm[WIDTH-2:0], m_ser};
        wl[c-1] = l_ser;
      end
      compared++;
      if ({obs_m(), obs_l()} !== {exp_m, exp_l}) begin
        mismatched++;
        $display("FAIL single c%0d: got m=%b l=%b want m=%b l=%b", c, obs_m(), obs_l(), exp_m, exp_l);
      end
    end
    compared++;
    if ({wm, wl} !== {8'hA5, 8'hA5}) begin
      mismatched++;
      $display("FAIL single_word: got m=%h l=%h want a5", wm, wl);
    end
  endtask

  task automatic test_back_to_back();
    int sv_count = 0;
    int fs_first = -1, fs_second = -1;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    for (int c = 1; c <= 2 * FL + 1; c++) begin
      step();
      if (c == 1) in_data = 8'h3C;
      if (c == FL + 1) in_valid = 1'b0;
      if (c <= 2 * FL && m_sv) sv_count++;
      if (m_fs && fs_first < 0) fs_first = c;
      else if (m_fs) fs_second = c;
      compared++;
      if ({obs_m(), obs_l()} !== {exp_m, exp_l}) begin
        mismatched++;
        $display("FAIL b2b c%0d: got m=%b l=%b want m=%b l=%b", c, obs_m(), obs_l(), exp_m, exp_l);
      end
    end
    compared++;
    if (sv_count !== 2 * FL || fs_first !== 1 || fs_second !== FL + 1) begin
      mismatched++;
      $display("FAIL b2b_shape: got valid=%0d fs=%0d,%0d want %0d fs=1,%0d",
               sv_count, fs_first, fs_second, 2 * FL, FL + 1);
    end
  endtask

  task automatic test_reset_mid_frame();
    in_data  = 8'hFF;
    in_valid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      in_valid = 1'b0;
      compared++;
      if ({obs_m(), obs_l()} !== {exp_m, exp_l}) begin
        mismatched++;
        $display("FAIL midrst_pre c%0d: got m=%b l=%b want m=%b l=%b", c, obs_m(), obs_l(), exp_m, exp_l);
      end
    end
    #2 rst = 1'b0;
    #1;
    compared++;
    if ({obs_m(), obs_l()} !== {5'b00001, 5'b00001}) begin
      mismatched++;
      $display("FAIL midrst_async: got m=%b l=%b want 00001", obs_m(), obs_l());
    end
    qm.delete();
    ql.delete();
    @(negedge clk);
    rst      = 1'b1;
    in_data  = 8'h81;
    in_valid = 1'b1;
    for (int c = 1; c <= FL + 1; c++) begin
      step();
      in_valid = 1'b0;
      compared++;
      if ({obs_m(), obs_l()} !== {exp_m, exp_l}) begin
        mismatched++;
        $display("FAIL midrst_next c%0d: got m=%b l=%b want m=%b l=%b", c, obs_m(), obs_l(), exp_m, exp_l);
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [WIDTH-1:0] seq;
    in_data  = 8'hC1;
    in_valid = 1'b1;
    for (int c = 1; c <= FL + 1; c++) begin
      step();
      in_valid = 1'b0;
      if (c <= WIDTH) seq = {seq[WIDTH-2:0], l_ser};
      compared++;
      if ({obs_m(), obs_l()} !== {exp_m, exp_l}) begin
        mismatched++;
        $display("FAIL lsb c%0d: got m=%b l=%b want m=%b l=%b", c, obs_m(), obs_l(), exp_m, exp_l);
      end
    end
    compared++;
    if (seq !== 8'b1000_0011) begin
      mismatched++;
      $display("FAIL lsb_seq: got %b want 10000011", seq);
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic [WIDTH-1:0] words [2] = '{8'hA5, 8'h07};
    logic             pars  [2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      in_data  = words[k];
      in_valid = 1'b1;
      for (int c = 1; c <= FL + 1; c++) begin
        step();
        in_valid = 1'b0;
        if (c == FL) begin
          compared++;
          if ({m_ser, m_lb, l_ser, l_lb} !== {pars[k], 1'b1, pars[k], 1'b1}) begin
            mismatched++;
            $display("FAIL parity_%h: got m=%b%b l=%b%b want bit=%b last=1",
                     words[k], m_ser, m_lb, l_ser, l_lb, pars[k]);
          end
        end
        compared++;
        if ({obs_m(), obs_l()} !== {exp_m, exp_l}) begin
          mismatched++;
          $display("FAIL parity c%0d: got m=%b l=%b want m=%b l=%b", c, obs_m(), obs_l(), exp_m, exp_l);
        end
      end
    end
  endtask
`endif

  task automatic test_busy_stall();
    int ready_seen = 0;
    in_data  = 8'h5A;
    in_valid = 1'b1;
    for (int c = 1; c <= 2 * FL + 1; c++) begin
      step();
      if (c == 1) in_data = 8'hC3;
      if (c == FL + 1) in_valid = 1'b0;
      if (c <= FL && m_ready) ready_seen++;
      if (c == FL + 1) begin
        compared++;
        if ({m_fs, m_ser, ready_seen} !== {1'b1, 1'b1, 32'd1}) begin
          mismatched++;
          $display("FAIL stall_accept: got fs=%b bit=%b ready_cycles=%0d want fs=1 bit=1 ready_cycles=1",
                   m_fs, m_ser, ready_seen);
        end
      end
      compared++;
      if ({obs_m(), obs_l()} !== {exp_m, exp_l}) begin
        mismatched++;
        $display("FAIL stall c%0d: got m=%b l=%b want m=%b l=%b", c, obs_m(), obs_l(), exp_m, exp_l);
      end
    end
  endtask

  task automatic test_random();
    logic held = 1'b0;
    for (int c = 1; c <= 400 + FL + 1; c++) begin
      if (c > 400) begin
        in_valid = 1'b0;
      end else if (!held) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = WIDTH'($urandom);
      end
      step();
      held = in_valid && !last_acc;
      compared++;
      if ({obs_m(), obs_l()} !== {exp_m, exp_l}) begin
        mismatched++;
        $display("FAIL random c%0d: got m=%b l=%b want m=%b l=%b", c, obs_m(), obs_l(), exp_m, exp_l);
      end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_lsb_first();
`ifdef PARITY_EN
    test_parity();
`endif
    test_busy_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
